// File: rtl/logic_unit_pkg.sv
// Shared types, select-code names and golden model for the 74181 logic-unit BIST.
package logic_unit_pkg;

  typedef logic [3:0] lu_sel_t;

  localparam lu_sel_t LU_NOT_A      = 4'h0;
  localparam lu_sel_t LU_NOR        = 4'h1;
  localparam lu_sel_t LU_NOTA_AND_B = 4'h2;
  localparam lu_sel_t LU_ZERO       = 4'h3;
  localparam lu_sel_t LU_NAND       = 4'h4;
  localparam lu_sel_t LU_NOT_B      = 4'h5;
  localparam lu_sel_t LU_XOR        = 4'h6;
  localparam lu_sel_t LU_A_AND_NOTB = 4'h7;
  localparam lu_sel_t LU_NOTA_OR_B  = 4'h8;
  localparam lu_sel_t LU_XNOR       = 4'h9;
  localparam lu_sel_t LU_PASS_B     = 4'hA;
  localparam lu_sel_t LU_AND        = 4'hB;
  localparam lu_sel_t LU_ONES       = 4'hC;
  localparam lu_sel_t LU_A_OR_NOTB  = 4'hD;
  localparam lu_sel_t LU_OR         = 4'hE;
  localparam lu_sel_t LU_PASS_A     = 4'hF;

  typedef enum logic [1:0] {
    LU_IDLE  = 2'd0,
    LU_RUN   = 2'd1,
    LU_DRAIN = 2'd2,
    LU_DONE  = 2'd3
  } lu_bist_state_t;

  // Operates on 32-bit operands; callers cast the result down to their width.
  function automatic logic [31:0] lu_golden(input lu_sel_t sel, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] f;
    f = '0;
    case (sel)
      LU_NOT_A:      f = ~a;
      LU_NOR:        f = ~(a | b);
      LU_NOTA_AND_B: f = ~a & b;
      LU_ZERO:       f = '0;
      LU_NAND:       f = ~(a & b);
      LU_NOT_B:      f = ~b;
      LU_XOR:        f = a ^ b;
      LU_A_AND_NOTB: f = a & ~b;
      LU_NOTA_OR_B:  f = ~a | b;
      LU_XNOR:       f = ~(a ^ b);
      LU_PASS_B:     f = b;
      LU_AND:        f = a & b;
      LU_ONES:       f = '1;
      LU_A_OR_NOTB:  f = a | ~b;
      LU_OR:         f = a | b;
      LU_PASS_A:     f = a;
      default:       f = '0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/lu_bist_delay.sv
// Fixed-latency {valid, data} shift line aligning expected results with the responder.
module lu_bist_delay #(
  parameter int DW  = 4,
  parameter int LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_flush,
  input  logic          i_vld,
  input  logic [DW-1:0] i_data,
  output logic          o_vld,
  output logic [DW-1:0] o_data
);

  generate
    if (LAT == 0) begin : g_thru
      assign o_vld  = i_vld;
      assign o_data = i_data;
    end else begin : g_line
      logic [LAT-1:0] r_vld;
      logic [DW-1:0]  r_data [LAT];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_vld <= '0;
          for (int i = 0; i < LAT; i++) r_data[i] <= '0;
        end else if (i_flush) begin
          r_vld <= '0;
        end else begin
          r_vld[0]  <= i_vld;
          r_data[0] <= i_data;
          for (int i = 1; i < LAT; i++) begin
            r_vld[i]  <= r_vld[i-1];
            r_data[i] <= r_data[i-1];
          end
        end
      end

      assign o_vld  = r_vld[LAT-1];
      assign o_data = r_data[LAT-1];
    end
  endgenerate

endmodule

// File: rtl/logic_unit_bist.sv
// BIST initiator sweeping every {s,a,b} vector into a 74181 logic unit and counting mismatches.
// Optional first-failure capture ports are enabled by defining LU_BIST_FAIL_LOG_EN.
module logic_unit_bist
  import logic_unit_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int RESULT_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_cnt,
  output logic [3:0]       dut_s,
  output logic [WIDTH-1:0] dut_a,
  output logic [WIDTH-1:0] dut_b,
  input  logic [WIDTH-1:0] dut_f
`ifdef LU_BIST_FAIL_LOG_EN
  ,
  output logic             fail_vld,
  output logic [3:0]       fail_s,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic [WIDTH-1:0] fail_f
`endif
);

  localparam int VW = 4 + 2 * WIDTH;
`ifdef LU_BIST_FAIL_LOG_EN
  localparam int PW = VW + WIDTH;
`else
  localparam int PW = WIDTH;
`endif
  localparam logic [2:0] DRAIN_INIT = 3'((RESULT_LAT > 0) ? RESULT_LAT - 1 : 0);

  lu_bist_state_t r_state, w_state_nxt;
  logic [VW-1:0]    r_vec, w_vec_nxt;
  logic [WIDTH-1:0] r_exp, w_exp_nxt;
  logic             r_vld;
  logic [2:0]       r_drain;
  logic [15:0]      r_err, w_err_nxt;
  logic             r_pass;
  logic             w_last, w_enter_run, w_miss;
  logic [PW-1:0]    w_issue, w_tail;
  logic             w_tail_vld;
  logic [WIDTH-1:0] w_tail_exp;

  assign w_last      = &r_vec;
  assign w_enter_run = (w_state_nxt == LU_RUN) && (r_state != LU_RUN);
  assign w_vec_nxt   = w_enter_run ? '0 : r_vec + 1'b1;
  assign w_exp_nxt   = WIDTH'(lu_golden(w_vec_nxt[VW-1 -: 4],
                                        32'(w_vec_nxt[2*WIDTH-1 -: WIDTH]),
                                        32'(w_vec_nxt[WIDTH-1:0])));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= LU_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      LU_IDLE, LU_DONE: if (start) w_state_nxt = LU_RUN;
      LU_RUN:           if (w_last) w_state_nxt = (RESULT_LAT == 0) ? LU_DONE : LU_DRAIN;
      LU_DRAIN:         if (r_drain == 3'd0) w_state_nxt = LU_DONE;
      default:          w_state_nxt = LU_IDLE;
    endcase
    if (abort) w_state_nxt = LU_IDLE;
  end

  // The issue register is the first stage; the delay line adds RESULT_LAT more.
`ifdef LU_BIST_FAIL_LOG_EN
  logic [VW-1:0] w_tail_vec;
  assign w_issue    = {r_vec, r_exp};
  assign w_tail_vec = w_tail[PW-1 -: VW];
`else
  assign w_issue    = r_exp;
`endif
  assign w_tail_exp = w_tail[WIDTH-1:0];

  lu_bist_delay #(.DW(PW), .LAT(RESULT_LAT)) u_delay (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (abort),
    .i_vld   (r_vld),
    .i_data  (w_issue),
    .o_vld   (w_tail_vld),
    .o_data  (w_tail)
  );

  assign w_miss    = w_tail_vld && (dut_f != w_tail_exp);
  assign w_err_nxt = (w_miss && (r_err != 16'hFFFF)) ? r_err + 16'd1 : r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec   <= '0;
      r_exp   <= '0;
      r_vld   <= 1'b0;
      r_drain <= '0;
      r_err   <= '0;
      r_pass  <= 1'b0;
    end else begin
      if (w_state_nxt == LU_RUN) begin
        r_vec <= w_vec_nxt;
        r_exp <= w_exp_nxt;
        r_vld <= 1'b1;
      end else begin
        r_vec <= '0;
        r_exp <= '0;
        r_vld <= 1'b0;
      end

      if (w_state_nxt == LU_DRAIN && r_state == LU_RUN) r_drain <= DRAIN_INIT;
      else if (r_state == LU_DRAIN && r_drain != 3'd0)   r_drain <= r_drain - 3'd1;

      if (w_enter_run) begin
        r_err  <= '0;
        r_pass <= 1'b0;
      end else if (abort) begin
        r_pass <= 1'b0;
      end else begin
        r_err <= w_err_nxt;
        if (w_state_nxt == LU_DONE && r_state != LU_DONE) r_pass <= (w_err_nxt == 16'd0);
      end
    end
  end

`ifdef LU_BIST_FAIL_LOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_vld <= 1'b0;
      fail_s   <= '0;
      fail_a   <= '0;
      fail_b   <= '0;
      fail_f   <= '0;
    end else if (w_enter_run) begin
      fail_vld <= 1'b0;
      fail_s   <= '0;
      fail_a   <= '0;
      fail_b   <= '0;
      fail_f   <= '0;
    end else if (!abort && w_miss && !fail_vld) begin
      fail_vld <= 1'b1;
      fail_s   <= w_tail_vec[VW-1 -: 4];
      fail_a   <= w_tail_vec[2*WIDTH-1 -: WIDTH];
      fail_b   <= w_tail_vec[WIDTH-1:0];
      fail_f   <= dut_f;
    end
  end
`endif

  assign busy    = (r_state == LU_RUN) || (r_state == LU_DRAIN);
  assign done    = (r_state == LU_DONE);
  assign pass    = r_pass;
  assign err_cnt = r_err;
  assign dut_s   = r_vec[VW-1 -: 4];
  assign dut_a   = r_vec[2*WIDTH-1 -: WIDTH];
  assign dut_b   = r_vec[WIDTH-1:0];

endmodule

// File: tb/tb_logic_unit_bist.sv
// Bench: three BIST instances (RESULT_LAT 0/2/1) each driving a behavioural logic unit with injectable faults.
module tb_logic_unit_bist;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_a [3];
  logic        abort_a [3];
  logic        busy_a  [3];
  logic        done_a  [3];
  logic        pass_a  [3];
  logic [15:0] err_a   [3];
  logic [3:0]  s_a     [3];
  logic [3:0]  a_a     [3];
  logic [3:0]  b_a     [3];
  logic [3:0]  f_a     [3];
  int          mode    [3];
`ifdef LU_BIST_FAIL_LOG_EN
  logic        fvld_a  [3];
  logic [3:0]  fs_a    [3];
  logic [3:0]  fa_a    [3];
  logic [3:0]  fb_a    [3];
  logic [3:0]  ff_a    [3];
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [3:0] ref_f(input logic [3:0] s, input logic [3:0] a, input logic [3:0] b);
    case (s)
      4'h0: ref_f = ~a;
      4'h1: ref_f = ~a & ~b;
      4'h2: ref_f = ~a & b;
      4'h3: ref_f = 4'h0;
      4'h4: ref_f = ~a | ~b;
      4'h5: ref_f = ~b;
      4'h6: ref_f = (a & ~b) | (~a & b);
      4'h7: ref_f = a & ~b;
      4'h8: ref_f = ~a | b;
      4'h9: ref_f = (a & b) | (~a & ~b);
      4'hA: ref_f = b;
      4'hB: ref_f = a & b;
      4'hC: ref_f = 4'hF;
      4'hD: ref_f = a | ~b;
      4'hE: ref_f = a | b;
      default: ref_f = a;
    endcase
  endfunction

  // 0 good, 1 f[0] stuck-1 when s=3, 2 all bits inverted,
  // 3 f[3] flipped when s=F and a==b, 4 single bad vector s=C a=5 b=A
  function automatic logic [3:0] lu_model(input int m, input logic [3:0] s, input logic [3:0] a,
                                          input logic [3:0] b);
    logic [3:0] g;
    g = ref_f(s, a, b);
    case (m)
      1: lu_model = (s == 4'h3) ? (g | 4'b0001) : g;
      2: lu_model = ~g;
      3: lu_model = (s == 4'hF && a == b) ? (g ^ 4'b1000) : g;
      4: lu_model = (s == 4'hC && a == 4'h5 && b == 4'hA) ? 4'h0 : g;
      default: lu_model = g;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_u
    localparam int LAT = (g == 0) ? 0 : ((g == 1) ? 2 : 1);
    logic [3:0] w_f0, r_p1, r_p2;
    assign w_f0 = lu_model(mode[g], s_a[g], a_a[g], b_a[g]);
    always_ff @(posedge clk) begin
      r_p1 <= w_f0;
      r_p2 <= r_p1;
    end
    assign f_a[g] = (g == 0) ? w_f0 : r_p2;

    logic_unit_bist #(.WIDTH(4), .RESULT_LAT(LAT)) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start_a[g]),
      .abort   (abort_a[g]),
      .busy    (busy_a[g]),
      .done    (done_a[g]),
      .pass    (pass_a[g]),
      .err_cnt (err_a[g]),
      .dut_s   (s_a[g]),
      .dut_a   (a_a[g]),
      .dut_b   (b_a[g]),
      .dut_f   (f_a[g])
`ifdef LU_BIST_FAIL_LOG_EN
      ,
      .fail_vld (fvld_a[g]),
      .fail_s   (fs_a[g]),
      .fail_a   (fa_a[g]),
      .fail_b   (fb_a[g]),
      .fail_f   (ff_a[g])
`endif
    );
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_idle_outputs(input string tag, input int k);
    chk({tag, "_busy"}, int'(busy_a[k]), 0);
    chk({tag, "_done"}, int'(done_a[k]), 0);
    chk({tag, "_pass"}, int'(pass_a[k]), 0);
    chk({tag, "_err"},  int'(err_a[k]),  0);
    chk({tag, "_s"},    int'(s_a[k]),    0);
    chk({tag, "_a"},    int'(a_a[k]),    0);
    chk({tag, "_b"},    int'(b_a[k]),    0);
  endtask

  // Cycles counted from the first sample showing vector 0 until done is seen.
  task automatic run_bist(input int k, output int cyc, output int bcnt);
    start_a[k] = 1'b1;
    tick(1);
    start_a[k] = 1'b0;
    chk("entry_err_cleared", int'(err_a[k]), 0);
    chk("entry_done_low", int'(done_a[k]), 0);
    cyc  = 0;
    bcnt = 0;
    while (!done_a[k] && cyc < 6000) begin
      if (busy_a[k]) bcnt++;
      tick(1);
      cyc++;
    end
    if (!done_a[k]) begin
      checks++;
      failures++;
      $display("FAIL run_timeout inst=%0d actual=no_done required=done", k);
    end
  endtask

  typedef struct {
    int inst;
    int md;
    int exp_err;
    int exp_pass;
    int exp_cyc;
  } row_t;

  row_t rows [8];

  initial begin
    int cyc, bcnt;
    rows[0] = '{0, 0, 0,    1, 4096};
    rows[1] = '{0, 1, 256,  0, 4096};
    rows[2] = '{0, 2, 4096, 0, 4096};
    rows[3] = '{0, 2, 4096, 0, 4096};
    rows[4] = '{0, 3, 16,   0, 4096};
    rows[5] = '{0, 4, 1,    0, 4096};
    rows[6] = '{1, 0, 0,    1, 4098};
    rows[7] = '{2, 0, -1,   0, 4097};

    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      start_a[k] = 1'b0;
      abort_a[k] = 1'b0;
      mode[k]    = 0;
    end
    tick(3);
    chk_idle_outputs("reset0", 0);
    chk_idle_outputs("reset1", 1);
    rst_n = 1'b1;
    tick(2);

    for (int r = 0; r < 8; r++) begin
      mode[rows[r].inst] = rows[r].md;
      run_bist(rows[r].inst, cyc, bcnt);
      chk($sformatf("row%0d_done_cycles", r), cyc, rows[r].exp_cyc);
      chk($sformatf("row%0d_busy_cycles", r), bcnt, rows[r].exp_cyc);
      chk($sformatf("row%0d_pass", r), int'(pass_a[rows[r].inst]), rows[r].exp_pass);
      if (rows[r].exp_err >= 0)
        chk($sformatf("row%0d_err_cnt", r), int'(err_a[rows[r].inst]), rows[r].exp_err);
`ifdef LU_BIST_FAIL_LOG_EN
      if (rows[r].md == 1) begin
        chk("flog_vld", int'(fvld_a[0]), 1);
        chk("flog_s", int'(fs_a[0]), 3);
        chk("flog_a", int'(fa_a[0]), 0);
        chk("flog_b", int'(fb_a[0]), 0);
        chk("flog_f", int'(ff_a[0]), 1);
      end
      if (rows[r].md == 4) begin
        chk("flog4_s", int'(fs_a[0]), 12);
        chk("flog4_a", int'(fa_a[0]), 5);
        chk("flog4_b", int'(fb_a[0]), 10);
        chk("flog4_f", int'(ff_a[0]), 0);
      end
`endif
      tick(2);
    end

    // start and abort together from DONE: abort wins, done drops
    mode[0] = 0;
    start_a[0] = 1'b1;
    abort_a[0] = 1'b1;
    tick(1);
    start_a[0] = 1'b0;
    abort_a[0] = 1'b0;
    chk("start_abort_busy", int'(busy_a[0]), 0);
    chk("start_abort_done", int'(done_a[0]), 0);

    // abort at cycle 100 of RUN, then restart from vector 0
    start_a[0] = 1'b1;
    tick(1);
    start_a[0] = 1'b0;
    tick(100);
    chk("v100_a", int'(a_a[0]), 6);
    chk("v100_b", int'(b_a[0]), 4);
    abort_a[0] = 1'b1;
    tick(1);
    abort_a[0] = 1'b0;
    chk("abort_busy", int'(busy_a[0]), 0);
    chk("abort_done", int'(done_a[0]), 0);
    chk("abort_s", int'(s_a[0]), 0);
    chk("abort_a", int'(a_a[0]), 0);
    chk("abort_b", int'(b_a[0]), 0);
    start_a[0] = 1'b1;
    tick(1);
    start_a[0] = 1'b0;
    chk("restart_busy", int'(busy_a[0]), 1);
    chk("restart_vec0", int'({s_a[0], a_a[0], b_a[0]}), 0);
    tick(1);
    chk("restart_vec1", int'({s_a[0], a_a[0], b_a[0]}), 1);
    abort_a[0] = 1'b1;
    tick(1);
    abort_a[0] = 1'b0;

    // LAT=2 instance, inverting responder, start held high, reset in DRAIN
    mode[1] = 2;
    start_a[1] = 1'b1;
    tick(1);
    tick(100);
    chk("held_v100_busy", int'(busy_a[1]), 1);
    chk("held_v100_vec", int'({s_a[1], a_a[1], b_a[1]}), 100);
    tick(3996);
    chk("drain_busy", int'(busy_a[1]), 1);
    chk("drain_vec_zero", int'({s_a[1], a_a[1], b_a[1]}), 0);
    chk("drain_err", int'(err_a[1]), 4094);
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("rst_drain", 1);
    start_a[1] = 1'b0;
    #3;
    rst_n = 1'b1;
    tick(3);
    chk("post_rst_busy", int'(busy_a[1]), 0);
    chk("post_rst_done", int'(done_a[1]), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
